// File: rtl/count_display_driver.sv
// Captures a 4-bit counter value, splits it into two BCD digits and scans them onto one
// 7-segment bus. Optional leading-zero blanking: define COUNT_DISPLAY_LEADING_ZERO_BLANK_EN.
module count_display_driver #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] count_in,
  output logic [6:0] seg,
  output logic [1:0] dig
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

  typedef enum logic {
    UNITS = 1'b0,
    TENS  = 1'b1
  } scan_state_t;

  scan_state_t      state_r, state_s;
  logic [3:0]       cap_r;
  logic [PRE_W-1:0] pre_r;
  logic             tens_s;
  logic [3:0]       units_s;
  logic             pre_wrap_s;
  logic [6:0]       seg_s;
  logic [1:0]       dig_s;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'h3F;
      4'd1:    pattern = 7'h06;
      4'd2:    pattern = 7'h5B;
      4'd3:    pattern = 7'h4F;
      4'd4:    pattern = 7'h66;
      4'd5:    pattern = 7'h6D;
      4'd6:    pattern = 7'h7D;
      4'd7:    pattern = 7'h07;
      4'd8:    pattern = 7'h7F;
      4'd9:    pattern = 7'h6F;
      default: pattern = 7'h00;
    endcase
    return pattern;
  endfunction

  // BCD split, scan next-state and the next segment/digit drive
  always_comb begin
    tens_s     = (cap_r >= 4'd10);
    units_s    = cap_r;
    pre_wrap_s = (pre_r == PRE_MAX);
    state_s    = state_r;
    seg_s      = 7'h00;
    dig_s      = 2'b00;
    if (tens_s) begin
      units_s = cap_r - 4'd10;
    end else begin
      units_s = cap_r;
    end
    case (state_r)
      UNITS: begin
        seg_s = seg_encode(units_s);
        dig_s = 2'b01;
        if (pre_wrap_s) begin
          state_s = TENS;
        end else begin
          state_s = UNITS;
        end
      end
      TENS: begin
        dig_s = 2'b10;
`ifdef COUNT_DISPLAY_LEADING_ZERO_BLANK_EN
        if (tens_s) begin
          seg_s = seg_encode(4'd1);
        end else begin
          seg_s = 7'h00;
        end
`else
        seg_s = seg_encode({3'b000, tens_s});
`endif
        if (pre_wrap_s) begin
          state_s = UNITS;
        end else begin
          state_s = TENS;
        end
      end
      default: begin
        state_s = UNITS;
      end
    endcase
  end

  // Scan state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= UNITS;
    end else begin
      state_r <= state_s;
    end
  end

  // Capture register, prescaler and registered display outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cap_r <= 4'd0;
      pre_r <= '0;
      seg   <= 7'h00;
      dig   <= 2'b00;
    end else begin
      if (load) begin
        cap_r <= count_in;
      end
      if (pre_wrap_s) begin
        pre_r <= '0;
      end else begin
        pre_r <= pre_r + PRE_W'(1);
      end
      seg <= seg_s;
      dig <= dig_s;
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench for count_display_driver: directed test-plan steps plus random loads,
// compared against an edge-indexed arithmetic model of the display scan.
module tb_count_display_driver;

  localparam int SD = 4;
`ifdef COUNT_DISPLAY_LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       load = 1'b0;
  logic [3:0] count_in = 4'd0;
  logic [6:0] seg;
  logic [1:0] dig;

  int errors = 0;
  int checks = 0;

  // Reference model: captured value and number of edges since reset release.
  int m_cap = 0;
  int m_k   = 0;
  logic [6:0] exp_seg;
  logic [1:0] exp_dig;
  logic [6:0] enc [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  count_display_driver #(.SCAN_DIV(SD)) dut (
    .clk(clk), .clr(clr), .load(load), .count_in(count_in), .seg(seg), .dig(dig)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] s_exp, input logic [1:0] d_exp);
    checks++;
    assert (seg === s_exp) else begin
      errors++;
      $error("FAIL %s seg: observed=%h expected=%h", tag, seg, s_exp);
    end
    checks++;
    assert (dig === d_exp) else begin
      errors++;
      $error("FAIL %s dig: observed=%b expected=%b", tag, dig, d_exp);
    end
  endtask

  // One clock edge: drive inputs, advance the model, compare just after the edge.
  task automatic tick(input string tag, input logic ld, input logic [3:0] v);
    int shown;
    bit tens_phase;
    load     = ld;
    count_in = v;
    @(posedge clk);
    shown = m_cap;
    if (ld) m_cap = v;
    m_k++;
    tens_phase = (((m_k - 1) / SD) % 2) == 1;
    if (tens_phase) begin
      exp_dig = 2'b10;
      exp_seg = (BLANK && shown < 10) ? 7'h00 : enc[shown / 10];
    end else begin
      exp_dig = 2'b01;
      exp_seg = enc[shown % 10];
    end
    #1;
    check(tag, exp_seg, exp_dig);
    @(negedge clk);
  endtask

  initial begin
    // Reset held with clock running
    repeat (3) @(posedge clk);
    #1 check("reset_hold", 7'h00, 2'b00);
    @(negedge clk);
    clr = 1'b0;

    // Load 7 then observe two full frames
    tick("load7", 1'b1, 4'd7);
    for (int i = 0; i < 4 * SD; i++) tick("show7", 1'b0, 4'd0);

    // Load 13 across two frames
    tick("load13", 1'b1, 4'd13);
    for (int i = 0; i < 4 * SD; i++) tick("show13", 1'b0, 4'd2);

    // Wrap 15 -> 0
    tick("load15", 1'b1, 4'd15);
    for (int i = 0; i < 2 * SD; i++) tick("show15", 1'b0, 4'd3);
    tick("load0", 1'b1, 4'd0);
    for (int i = 0; i < 2 * SD; i++) tick("show0", 1'b0, 4'd9);

    // Hold: load low while count_in sweeps
    tick("load11", 1'b1, 4'd11);
    for (int i = 0; i < 16; i++) tick("hold", 1'b0, 4'(i));

    // Random loads and values
    for (int i = 0; i < 80; i++)
      tick("random", ($urandom % 3) == 0, 4'($urandom % 16));

    // Reset mid-frame during a TENS phase
    tick("load12", 1'b1, 4'd12);
    for (int i = 0; i < 4 * SD && exp_dig != 2'b10; i++) tick("seek_tens", 1'b0, 4'd0);
    checks++;
    assert (exp_dig === 2'b10) else begin
      errors++;
      $error("FAIL seek_tens: observed=%b expected=%b", exp_dig, 2'b10);
    end
    #2 clr = 1'b1;
    #1 check("async_clr", 7'h00, 2'b00);
    @(posedge clk);
    #1 check("clr_held", 7'h00, 2'b00);
    @(negedge clk);
    clr   = 1'b0;
    m_cap = 0;
    m_k   = 0;
    tick("post_reset", 1'b0, 4'd5);
    checks++;
    assert (seg === 7'h3F && dig === 2'b01) else begin
      errors++;
      $error("FAIL post_reset_first: observed=%h/%b expected=3f/01", seg, dig);
    end
    for (int i = 0; i < 2 * SD; i++) tick("post_reset_scan", 1'b0, 4'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_display_driver.md
# count_display_driver

Downstream stage for the 4-bit synchronous up counter. Captures the counter's 4-bit value (0–15) and converts it to two BCD digits. Time-multiplexes the digits onto one shared 7-segment bus with one-hot digit enables for the lab display board. It sits between the counter's Q3..Q0 outputs and the board's segment/digit pins.

## Interface
- SCAN_DIV, default 4: clk cycles each digit stays selected; legal range 1..255.
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  asynchronous, active-high reset.
- load  in  1  capture enable for count_in.
- count_in  in  4  counter value, Q3 = bit 3 … Q0 = bit 0.
- seg  out  7  segment drive, active-high; seg[6:0] = g,f,e,d,c,b,a.
- dig  out  2  one-hot digit enable, active-high; dig[0] = units, dig[1] = tens.

## Operation
- **Capture register `cap` (4 bits).** On a rising edge with load=1, cap <= count_in. With load=0, cap holds.
  - The counter changes on falling clk edges, so count_in is stable at every rising edge and needs no synchroniser.
- **BCD split (combinational from cap).**
  - tens = (cap >= 10).
  - units = cap − 10 when tens = 1, otherwise cap.
  - Tens digit is only ever 0 or 1.
- **Prescaler `pre`.**
  - Width is ceil(log2(SCAN_DIV)), with a minimum of 1.
  - Counts 0..SCAN_DIV−1, then wraps to 0.
- **Scan FSM, two states: UNITS and TENS.**
  - Leaves reset in UNITS.
  - Toggles UNITS↔TENS on each edge where pre == SCAN_DIV−1.
  - With SCAN_DIV=1, it toggles on every edge.
- **Output registers.** Each edge loads:
  - seg <= encode(digit selected by the current state, from the current cap).
  - dig <= 2'b01 in UNITS, 2'b10 in TENS.
- **Encoding (hex, gfedcba):** 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- **Reset.** clr=1 immediately forces cap=0, pre=0, state=UNITS, seg=7'h00, dig=2'b00, regardless of clk. This applies mid-scan as well.
- **Simultaneous load and digit switch.** Both take effect on the same edge. The newly selected digit shows the new cap on the following edge.
- **Wrap-around.** 15→0 on count_in needs no special handling. cap simply reloads.

## Timing
- **Load latency.** With load=1 sampled at edge N, cap updates at N. seg/dig reflect the new value after edge N+1, provided that digit is selected.
- **Post-reset start.** At the first rising edge after clr deasserts:
  - pre goes 0→1 (it wraps to 0 instead when SCAN_DIV=1).
  - seg/dig load the UNITS digit of cap=0, so dig=01, seg=3F.
- **Scan period.** Each digit is enabled for exactly SCAN_DIV consecutive cycles. The full refresh frame is 2·SCAN_DIV cycles.
- **Output transitions.** dig and seg change on the same edge, never separately. dig is never 2'b11.
  - Consequence: dig=2'b00 occurs only during reset and until the first edge after it.
- **No combinational path** from any input to seg or dig.

## Configuration
- Macro: COUNT_DISPLAY_LEADING_ZERO_BLANK_EN.
- **Defined:** while the TENS digit is selected and tens=0, seg=7'h00. dig[1] is still asserted, so scan timing is unchanged.
- **Undefined:** a zero tens digit displays 3F.
- The UNITS digit is never blanked.

## Test plan
- **Reset.** Hold clr=1 with clk toggling → seg=00, dig=00. Assert clr asynchronously between edges → outputs clear before the next edge.
- **Load 7, SCAN_DIV=4.**
  - For 4 cycles: dig=01, seg=07.
  - Next 4 cycles: dig=10, seg=3F (seg=00 with the macro defined).
  - Pattern repeats.
- **Load 13.** UNITS phase seg=4F; TENS phase seg=06. Check across two full frames.
- **Wrap.** Drive count_in 15 then 0, each with a load pulse.
  - Value 15: seg=6D / 06.
  - Value 0: seg=3F / 3F (3F / 00 with the macro).
  - The update is visible exactly one edge after the load edge.
- **Hold.** load=0 while count_in sweeps 0..15 → seg/dig keep showing the last captured value.
- **Reset mid-frame.** Assert clr during a TENS phase (dig=10), then release.
  - Outputs go to 0 immediately.
  - The first post-release edge gives dig=01, seg=3F.
  - The UNITS phase lasts SCAN_DIV cycles from that edge.
